// File: rtl/alu_issue_if.sv
// Signal bundle between decode, the multicycle ALU and writeback for alu_issue_ctrl.
// The master view belongs to the controller; the slave view to its surroundings.
interface alu_issue_if #(
  parameter int CNT_W = 8
);
  logic             i_req_valid;
  logic             o_req_ready;
  logic [31:0]      i_req_a;
  logic [31:0]      i_req_b;
  logic [2:0]       i_req_funct3;
  logic [6:0]       i_req_funct7;
  logic             i_req_imm;
  logic [4:0]       i_req_rd;
  logic             i_flush;

  logic             o_alu_en;
  logic [31:0]      o_alu_a;
  logic [31:0]      o_alu_b;
  logic [2:0]       o_alu_funct3;
  logic [6:0]       o_alu_funct7;
  logic             o_alu_imm;
  logic             i_alu_busy;
  logic [31:0]      i_alu_out;

  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [31:0]      o_rsp_data;
  logic [4:0]       o_rsp_rd;
  logic             o_timeout;
  logic [CNT_W-1:0] o_latency;

  modport master (
    input  i_req_valid, i_req_a, i_req_b, i_req_funct3, i_req_funct7, i_req_imm,
           i_req_rd, i_flush, i_alu_busy, i_alu_out, i_rsp_ready,
    output o_req_ready, o_alu_en, o_alu_a, o_alu_b, o_alu_funct3, o_alu_funct7,
           o_alu_imm, o_rsp_valid, o_rsp_data, o_rsp_rd, o_timeout, o_latency
  );

  modport slave (
    output i_req_valid, i_req_a, i_req_b, i_req_funct3, i_req_funct7, i_req_imm,
           i_req_rd, i_flush, i_alu_busy, i_alu_out, i_rsp_ready,
    input  o_req_ready, o_alu_en, o_alu_a, o_alu_b, o_alu_funct3, o_alu_funct7,
           o_alu_imm, o_rsp_valid, o_rsp_data, o_rsp_rd, o_timeout, o_latency
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: registers one decoded op, holds it on the ALU while busy,
// captures the result for writeback and enforces a busy watchdog.
module alu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        i_clk_n,
  input  logic        i_rst_n,
  alu_issue_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   CNT_LIMIT = (CNT_W+1)'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] latency_q, latency_d;
  logic             alu_en_q, alu_en_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [6:0]       funct7_q, funct7_d;
  logic             imm_q, imm_d;
  logic [4:0]       op_rd_q, op_rd_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [4:0]       rsp_rd_q, rsp_rd_d;

  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_next;
  logic             req_ready;
  logic             accept;
  logic             timeout;

  // The extra bit lets the watchdog compare see TIMEOUT_CYCLES even when it equals 2^CNT_W.
  assign cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign cnt_next = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_inc[CNT_W-1:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    req_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_HOLD: req_ready = bus.i_rsp_ready;
      default: req_ready = 1'b0;
    endcase
    if (bus.i_flush) req_ready = 1'b0;
  end

  assign accept = bus.i_req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latency_d  = latency_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    funct3_d   = funct3_q;
    funct7_d   = funct7_q;
    imm_d      = imm_q;
    op_rd_d    = op_rd_q;
    rsp_data_d = rsp_data_q;
    rsp_rd_d   = rsp_rd_q;
    timeout    = 1'b0;

    if (bus.i_flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) state_d = ST_EXEC;
        end
        ST_EXEC: begin
          cnt_d = cnt_next;
          if (!bus.i_alu_busy) begin
            rsp_data_d = bus.i_alu_out;
            rsp_rd_d   = op_rd_q;
            latency_d  = cnt_next;
            state_d    = ST_HOLD;
          end else if (cnt_inc == CNT_LIMIT) begin
            timeout = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          // Retiring and accepting in one cycle goes straight back to EXEC with no bubble.
          if (bus.i_rsp_ready) state_d = accept ? ST_EXEC : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (accept) begin
      alu_a_d  = bus.i_req_a;
      alu_b_d  = bus.i_req_b;
      funct3_d = bus.i_req_funct3;
      funct7_d = bus.i_req_funct7;
      imm_d    = bus.i_req_imm;
      op_rd_d  = bus.i_req_rd;
      cnt_d    = '0;
    end

    alu_en_d    = (state_d == ST_EXEC);
    rsp_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge i_clk_n) begin
    // NOTE: reset is synchronous and active-low, so it is tested inside the clocked block only.
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      latency_q   <= '0;
      alu_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      imm_q       <= 1'b0;
      op_rd_q     <= '0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      latency_q   <= latency_d;
      alu_en_q    <= alu_en_d;
      rsp_valid_q <= rsp_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      funct3_q    <= funct3_d;
      funct7_q    <= funct7_d;
      imm_q       <= imm_d;
      op_rd_q     <= op_rd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  assign bus.o_req_ready  = req_ready;
  assign bus.o_alu_en     = alu_en_q;
  assign bus.o_alu_a      = alu_a_q;
  assign bus.o_alu_b      = alu_b_q;
  assign bus.o_alu_funct3 = funct3_q;
  assign bus.o_alu_funct7 = funct7_q;
  assign bus.o_alu_imm    = imm_q;
  assign bus.o_rsp_valid  = rsp_valid_q;
  assign bus.o_rsp_data   = rsp_data_q;
  assign bus.o_rsp_rd     = rsp_rd_q;
  assign bus.o_timeout    = timeout;
  assign bus.o_latency    = latency_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a behavioural ALU with programmable busy time,
// directed scenarios followed by randomized ops, all checked against transaction-level expectations.
module tb_alu_issue_ctrl;

  localparam int TO      = 64;
  localparam int CW      = 8;
  localparam int LAT_MAX = (1 << CW) - 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        imm;
    logic [4:0]  rd;
    int          busy;
  } op_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if #(.CNT_W(CW)) bus ();

  alu_issue_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .i_clk_n (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int model_lat = 0;

  // Behavioural ALU: each op stays busy for a bench-chosen number of enable cycles.
  int busy_cfg_next = 0;
  int busy_cur      = 0;
  int en_cycles     = 0;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic imm);
    logic alt;
    alt = (f7 == 7'b0100000);
    if (f7 == 7'b0000001) return a * b;
    case (f3)
      3'd0:    return (alt && !imm) ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'd0, $signed(a) < $signed(b)};
      3'd3:    return {31'd0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.i_req_valid && bus.o_req_ready) busy_cur <= busy_cfg_next;
    en_cycles <= bus.o_alu_en ? en_cycles + 1 : 0;
  end

  assign bus.i_alu_busy = bus.o_alu_en && (en_cycles < busy_cur);
  assign bus.i_alu_out  = bus.i_alu_busy ? 32'hDEAD_BEEF
                        : alu_ref(bus.o_alu_a, bus.o_alu_b, bus.o_alu_funct3,
                                  bus.o_alu_funct7, bus.o_alu_imm);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                                input logic [6:0] f7, input logic imm, input logic [4:0] rd,
                                input int busy);
    op_t o;
    o.a = a; o.b = b; o.f3 = f3; o.f7 = f7; o.imm = imm; o.rd = rd; o.busy = busy;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  sel;
    o.a   = $urandom;
    o.b   = $urandom;
    o.f3  = 3'($urandom_range(0, 7));
    sel   = $urandom_range(0, 2);
    o.f7  = (sel == 0) ? 7'b0000000 : (sel == 1) ? 7'b0100000 : 7'b0000001;
    o.imm = 1'($urandom_range(0, 1));
    o.rd  = 5'($urandom_range(0, 31));
    o.busy = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 10) : $urandom_range(0, 6);
    return o;
  endfunction

  function automatic logic [31:0] exp_result(input op_t op);
    return alu_ref(op.a, op.b, op.f3, op.f7, op.imm);
  endfunction

  task automatic drive_req(input op_t op);
    bus.i_req_a      = op.a;
    bus.i_req_b      = op.b;
    bus.i_req_funct3 = op.f3;
    bus.i_req_funct7 = op.f7;
    bus.i_req_imm    = op.imm;
    bus.i_req_rd     = op.rd;
    bus.i_req_valid  = 1'b1;
    busy_cfg_next    = op.busy;
  endtask

  // Present op from IDLE; returns just after the accepting edge.
  task automatic accept_from_idle(input op_t op, input string tag);
    @(posedge clk); #1;
    drive_req(op);
    @(negedge clk);
    check({tag, "/idle_ready"}, 32'(bus.o_req_ready), 1);
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
  endtask

  // Walk the EXEC cycles of an accepted op and check the response or the watchdog outcome.
  task automatic exec_phase(input op_t op, input string tag, output bit timed_out);
    int n;
    timed_out = (op.busy >= TO);
    n = timed_out ? TO : op.busy + 1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check({tag, "/alu_en"},    32'(bus.o_alu_en), 1);
      check({tag, "/alu_a"},     bus.o_alu_a, op.a);
      check({tag, "/alu_b"},     bus.o_alu_b, op.b);
      check({tag, "/funct3"},    32'(bus.o_alu_funct3), 32'(op.f3));
      check({tag, "/funct7"},    32'(bus.o_alu_funct7), 32'(op.f7));
      check({tag, "/imm"},       32'(bus.o_alu_imm), 32'(op.imm));
      check({tag, "/exec_rdy"},  32'(bus.o_req_ready), 0);
      check({tag, "/exec_rspv"}, 32'(bus.o_rsp_valid), 0);
      check({tag, "/timeout"},   32'(bus.o_timeout), (timed_out && k == TO) ? 1 : 0);
    end
    @(negedge clk);
    check({tag, "/after_en"}, 32'(bus.o_alu_en), 0);
    check({tag, "/after_to"}, 32'(bus.o_timeout), 0);
    if (timed_out) begin
      check({tag, "/to_rspv"},  32'(bus.o_rsp_valid), 0);
      check({tag, "/to_ready"}, 32'(bus.o_req_ready), 1);
      check({tag, "/to_lat"},   32'(bus.o_latency), 32'(model_lat));
    end else begin
      model_lat = (op.busy + 1 > LAT_MAX) ? LAT_MAX : op.busy + 1;
      check({tag, "/rsp_valid"}, 32'(bus.o_rsp_valid), 1);
      check({tag, "/rsp_data"},  bus.o_rsp_data, exp_result(op));
      check({tag, "/rsp_rd"},    32'(bus.o_rsp_rd), 32'(op.rd));
      check({tag, "/latency"},   32'(bus.o_latency), 32'(model_lat));
    end
  endtask

  task automatic hold_wait(input op_t op, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "/hold_rspv"},  32'(bus.o_rsp_valid), 1);
      check({tag, "/hold_data"},  bus.o_rsp_data, exp_result(op));
      check({tag, "/hold_rd"},    32'(bus.o_rsp_rd), 32'(op.rd));
      check({tag, "/hold_ready"}, 32'(bus.o_req_ready), 0);
      check({tag, "/hold_en"},    32'(bus.o_alu_en), 0);
    end
  endtask

  task automatic retire(input string tag);
    @(posedge clk); #1;
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, "/ret_ready"}, 32'(bus.o_req_ready), 1);
    check({tag, "/ret_rspv"},  32'(bus.o_rsp_valid), 1);
    @(posedge clk); #1;
    bus.i_rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "/idle_rspv"}, 32'(bus.o_rsp_valid), 0);
    check({tag, "/idle_en"},   32'(bus.o_alu_en), 0);
  endtask

  task automatic retire_and_accept(input op_t op, input string tag);
    @(posedge clk); #1;
    bus.i_rsp_ready = 1'b1;
    drive_req(op);
    @(negedge clk);
    check({tag, "/b2b_ready"}, 32'(bus.o_req_ready), 1);
    @(posedge clk); #1;
    bus.i_rsp_ready = 1'b0;
    bus.i_req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  initial begin
    op_t op, op2;
    bit  to;
    bit  in_hold;

    bus.i_req_valid  = 1'b0;
    bus.i_req_a      = '0;
    bus.i_req_b      = '0;
    bus.i_req_funct3 = '0;
    bus.i_req_funct7 = '0;
    bus.i_req_imm    = 1'b0;
    bus.i_req_rd     = '0;
    bus.i_flush      = 1'b0;
    bus.i_rsp_ready  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/alu_en",  32'(bus.o_alu_en), 0);
    check("rst/rspv",    32'(bus.o_rsp_valid), 0);
    check("rst/timeout", 32'(bus.o_timeout), 0);
    check("rst/latency", 32'(bus.o_latency), 0);
    check("rst/data",    bus.o_rsp_data, 0);
    check("rst/rd",      32'(bus.o_rsp_rd), 0);
    check("rst/alu_a",   bus.o_alu_a, 0);
    check("rst/funct7",  32'(bus.o_alu_funct7), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD 5+7: response two cycles after accept, latency 1
    op = mk_op(32'd5, 32'd7, 3'b000, 7'b0000000, 1'b0, 5'd3, 0);
    accept_from_idle(op, "add");
    exec_phase(op, "add", to);
    check("add/data12", bus.o_rsp_data, 32'd12);
    check("add/lat1",   32'(bus.o_latency), 32'd1);
    retire("add");

    // SUB 3-5 with rd tag 17
    op = mk_op(32'd3, 32'd5, 3'b000, 7'b0100000, 1'b0, 5'd17, 0);
    accept_from_idle(op, "sub");
    exec_phase(op, "sub", to);
    check("sub/data", bus.o_rsp_data, 32'hFFFF_FFFE);
    check("sub/rd17", 32'(bus.o_rsp_rd), 32'd17);
    retire("sub");

    // MUL busy 33 cycles: latency 34, then a stalled writeback and a back-to-back op
    op  = mk_op(32'd1234, 32'd5678, 3'b000, 7'b0000001, 1'b0, 5'd9, 33);
    op2 = mk_op(32'hF0F0_1234, 32'h0FF0_4321, 3'b100, 7'b0000000, 1'b0, 5'd21, 0);
    accept_from_idle(op, "mul");
    exec_phase(op, "mul", to);
    check("mul/data", bus.o_rsp_data, 32'd7006652);
    check("mul/lat34", 32'(bus.o_latency), 32'd34);
    @(posedge clk); #1;
    drive_req(op2);
    hold_wait(op, 5, "mul");
    retire_and_accept(op2, "xor_b2b");
    exec_phase(op2, "xor_b2b", to);
    retire("xor_b2b");

    // Longest op that still completes: busy 63 gives latency 64
    op = mk_op(32'd100, 32'd3, 3'b001, 7'b0000000, 1'b1, 5'd4, 63);
    accept_from_idle(op, "b63");
    exec_phase(op, "b63", to);
    check("b63/lat64", 32'(bus.o_latency), 32'd64);
    retire("b63");

    // Busy stuck: watchdog abandons in the 64th EXEC cycle, latency untouched
    op = mk_op(32'd9, 32'd9, 3'b000, 7'b0000001, 1'b0, 5'd30, 500);
    accept_from_idle(op, "wdog");
    exec_phase(op, "wdog", to);
    check("wdog/fired", 32'(to), 1);
    repeat (3) begin
      @(negedge clk);
      check("wdog/no_rsp", 32'(bus.o_rsp_valid), 0);
    end

    // Flush during busy EXEC, with a competing request in the flush cycle
    op  = mk_op(32'd77, 32'd88, 3'b110, 7'b0000001, 1'b0, 5'd12, 20);
    op2 = mk_op(32'd1, 32'd2, 3'b000, 7'b0000000, 1'b0, 5'd13, 0);
    accept_from_idle(op, "fl_exec");
    repeat (4) @(negedge clk);
    check("fl_exec/busy", 32'(bus.i_alu_busy), 1);
    @(posedge clk); #1;
    bus.i_flush = 1'b1;
    drive_req(op2);
    @(negedge clk);
    check("fl_exec/ready0", 32'(bus.o_req_ready), 0);
    check("fl_exec/no_to",  32'(bus.o_timeout), 0);
    @(posedge clk); #1;
    bus.i_flush     = 1'b0;
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    check("fl_exec/en",    32'(bus.o_alu_en), 0);
    check("fl_exec/rspv",  32'(bus.o_rsp_valid), 0);
    check("fl_exec/idle",  32'(bus.o_req_ready), 1);
    check("fl_exec/lat",   32'(bus.o_latency), 32'(model_lat));
    repeat (3) begin
      @(negedge clk);
      check("fl_exec/no_rsp", 32'(bus.o_rsp_valid), 0);
    end

    // Flush of a held result
    op = mk_op(32'd40, 32'd2, 3'b111, 7'b0000000, 1'b0, 5'd6, 2);
    accept_from_idle(op, "fl_hold");
    exec_phase(op, "fl_hold", to);
    @(posedge clk); #1;
    bus.i_flush = 1'b1;
    @(negedge clk);
    check("fl_hold/ready0", 32'(bus.o_req_ready), 0);
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    @(negedge clk);
    check("fl_hold/rspv", 32'(bus.o_rsp_valid), 0);
    check("fl_hold/en",   32'(bus.o_alu_en), 0);
    check("fl_hold/lat",  32'(bus.o_latency), 32'(model_lat));

    // Reset while a result is held
    op = mk_op(32'd11, 32'd22, 3'b000, 7'b0000000, 1'b0, 5'd25, 1);
    accept_from_idle(op, "rst_hold");
    exec_phase(op, "rst_hold", to);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_hold/rspv", 32'(bus.o_rsp_valid), 0);
    check("rst_hold/en",   32'(bus.o_alu_en), 0);
    check("rst_hold/data", bus.o_rsp_data, 0);
    check("rst_hold/rd",   32'(bus.o_rsp_rd), 0);
    check("rst_hold/lat",  32'(bus.o_latency), 0);
    check("rst_hold/a",    bus.o_alu_a, 0);
    model_lat = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset in the middle of a busy op: enable drops and no response follows
    op = mk_op(32'd5, 32'd6, 3'b000, 7'b0000001, 1'b0, 5'd2, 10);
    accept_from_idle(op, "rst_exec");
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_exec/en", 32'(bus.o_alu_en), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("rst_exec/no_rsp", 32'(bus.o_rsp_valid), 0);
    end

    // Randomized ops, mixing idle starts and back-to-back handoffs
    in_hold = 1'b0;
    for (int i = 0; i < 30; i++) begin
      op = rand_op();
      if (in_hold && $urandom_range(0, 1) == 1) begin
        retire_and_accept(op, "rnd");
      end else begin
        if (in_hold) retire("rnd");
        accept_from_idle(op, "rnd");
      end
      exec_phase(op, "rnd", to);
      in_hold = !to;
      if (in_hold) hold_wait(op, $urandom_range(0, 3), "rnd");
    end
    if (in_hold) retire("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
